// File: rtl/adc_display_sequencer.sv
// Front-panel display sequencer: debounced buttons step source/tap/radix/channel selection.
// Define AUTO_SCAN_EN to add the SCAN source state that cycles channels on a dwell timer.
module adc_display_sequencer #(
  parameter int NUM_CH       = 3,
  parameter int DATA_W       = 16,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_CYC     = 100_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_mode,
  input  logic                        btn_proc,
  input  logic                        btn_radix,
  input  logic                        btn_ch,
  input  logic [DATA_W-1:0]           switches_in,
  input  logic [NUM_CH*3*DATA_W-1:0]  ch_data,
  input  logic [DATA_W-1:0]           bcd_in,
  output logic [DATA_W-1:0]           bin_out,
  output logic [DATA_W-1:0]           display_out,
  output logic [$clog2(NUM_CH)-1:0]   ch_sel,
  output logic [NUM_CH-1:0]           ch_en,
  output logic [1:0]                  proc_sel,
  output logic [1:0]                  src_state,
  output logic                        radix_bcd
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int DB_W = $clog2(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    S_ZERO   = 2'd0,
    S_SWITCH = 2'd1,
    S_ADC    = 2'd2,
    S_SCAN   = 2'd3
  } src_t;

  if (NUM_CH < 2 || NUM_CH > 8 || DEBOUNCE_CYC < 2 || SCAN_CYC < 2) begin : g_param_check
    $error("adc_display_sequencer: parameter out of range");
  end

  logic [3:0] btn_raw;
  logic [3:0] press;
  assign btn_raw = {btn_ch, btn_radix, btn_proc, btn_mode};

  // Counter runs only while the synchronised level differs from the accepted one.
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic            s1, s2, lvl, lvl_d;
    logic [DB_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= btn_raw[b];
        s2    <= s1;
        lvl_d <= lvl;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end
    assign press[b] = lvl & ~lvl_d;
  end

  logic [DATA_W-1:0] taps [NUM_CH][3];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar t = 0; t < 3; t++) begin : g_tap
      assign taps[c][t] = ch_data[(3*c+t)*DATA_W +: DATA_W];
    end
  end

  src_t              state, state_nxt;
  logic [1:0]        proc_nxt;
  logic              radix_nxt;
  logic [CH_W-1:0]   ch_nxt;
  logic [DATA_W-1:0] bin_nxt;
  logic              ch_step;

`ifdef AUTO_SCAN_EN
  localparam int SC_W = $clog2(SCAN_CYC);
  logic [SC_W-1:0] scan_tmr, scan_tmr_nxt;
`endif

  always_comb begin
    state_nxt = state;
    proc_nxt  = proc_sel;
    radix_nxt = radix_bcd;
    ch_nxt    = ch_sel;
    ch_step   = 1'b0;
    bin_nxt   = '0;

    if (press[0]) begin
      case (state)
        S_ZERO:   state_nxt = S_SWITCH;
        S_SWITCH: state_nxt = S_ADC;
`ifdef AUTO_SCAN_EN
        S_ADC:    state_nxt = S_SCAN;
`endif
        default:  state_nxt = S_ZERO;
      endcase
    end
    if (press[1]) proc_nxt = (proc_sel == 2'd2) ? 2'd0 : proc_sel + 2'd1;
    if (press[2]) radix_nxt = ~radix_bcd;

`ifdef AUTO_SCAN_EN
    // Timer idles at zero outside SCAN, so entering SCAN always starts a full dwell.
    scan_tmr_nxt = '0;
    if (state == S_SCAN) begin
      if (scan_tmr == SC_W'(SCAN_CYC - 1)) ch_step = 1'b1;
      else                                 scan_tmr_nxt = scan_tmr + SC_W'(1);
    end else begin
      ch_step = press[3];
    end
`else
    ch_step = press[3];
`endif
    if (ch_step) ch_nxt = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);

    case (state)
      S_ZERO:   bin_nxt = '0;
      S_SWITCH: bin_nxt = switches_in;
      default:  bin_nxt = taps[ch_sel][proc_sel];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_ZERO;
      proc_sel  <= '0;
      radix_bcd <= 1'b0;
      ch_sel    <= '0;
      bin_out   <= '0;
    end else begin
      state     <= state_nxt;
      proc_sel  <= proc_nxt;
      radix_bcd <= radix_nxt;
      ch_sel    <= ch_nxt;
      bin_out   <= bin_nxt;
    end
  end

`ifdef AUTO_SCAN_EN
  always_ff @(posedge clk) begin
    if (reset) scan_tmr <= '0;
    else       scan_tmr <= scan_tmr_nxt;
  end
`endif

  assign src_state   = state;
  assign ch_en       = NUM_CH'(1) << ch_sel;
  assign display_out = radix_bcd ? bcd_in : bin_out;

endmodule

// File: tb/tb_adc_display_sequencer.sv
// Self-checking bench for adc_display_sequencer with a press-level behavioural model.
module tb_adc_display_sequencer;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DEB    = 4;
  localparam int SCAN   = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_mode, btn_proc, btn_radix, btn_ch;
  logic [DATA_W-1:0] switches_in, bcd_in, bin_out, display_out;
  logic [NUM_CH*3*DATA_W-1:0] ch_data;
  logic [1:0] ch_sel;
  logic [NUM_CH-1:0] ch_en;
  logic [1:0] proc_sel, src_state;
  logic radix_bcd;

  int checks = 0;
  int failures = 0;

  int m_src, m_proc, m_radix, m_ch;
  logic [DATA_W-1:0] taps [$];

  always #5 clk = ~clk;

  adc_display_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_proc(btn_proc), .btn_radix(btn_radix), .btn_ch(btn_ch),
    .switches_in(switches_in), .ch_data(ch_data), .bcd_in(bcd_in),
    .bin_out(bin_out), .display_out(display_out), .ch_sel(ch_sel), .ch_en(ch_en),
    .proc_sel(proc_sel), .src_state(src_state), .radix_bcd(radix_bcd)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_taps();
    ch_data = '0;
    for (int i = 0; i < NUM_CH*3; i++)
      ch_data = ch_data | ((NUM_CH*3*DATA_W)'(taps[i]) << (i*DATA_W));
  endtask

  task automatic randomize_taps();
    for (int i = 0; i < NUM_CH*3; i++) taps[i] = DATA_W'($urandom);
    load_taps();
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_ch, btn_radix, btn_proc, btn_mode} = m;
  endtask

  task automatic model_reset();
    m_src = 0; m_proc = 0; m_radix = 0; m_ch = 0;
  endtask

  // One accepted press of every button in m, evaluated against the pre-press settings.
  task automatic apply_press(input logic [3:0] m);
    int src0;
    src0 = m_src;
`ifdef AUTO_SCAN_EN
    if (m[0]) m_src = (m_src + 1) % 4;
`else
    if (m[0]) m_src = (m_src + 1) % 3;
`endif
    if (m[1]) m_proc = (m_proc + 1) % 3;
    if (m[2]) m_radix = 1 - m_radix;
    if (m[3] && src0 != 3) m_ch = (m_ch + 1) % NUM_CH;
  endtask

  task automatic press(input logic [3:0] m);
    set_btns(m);
    tick(DEB + 4);
    apply_press(m);
    set_btns(4'b0000);
    tick(DEB + 4);
  endtask

  function automatic logic [DATA_W-1:0] exp_bin();
    if (m_src == 0) return '0;
    if (m_src == 1) return switches_in;
    return taps[m_ch*3 + m_proc];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    set_btns(4'b0000);
    switches_in = DATA_W'($urandom);
    bcd_in = DATA_W'($urandom);
    randomize_taps();
    tick(3);
    checks++; if (src_state !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", src_state); end
    checks++; if (proc_sel !== 2'd0) begin failures++; $display("FAIL reset_proc got=%0d exp=0", proc_sel); end
    checks++; if (radix_bcd !== 1'b0) begin failures++; $display("FAIL reset_radix got=%0d exp=0", radix_bcd); end
    checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", ch_sel); end
    checks++; if (ch_en !== 3'b001) begin failures++; $display("FAIL reset_ch_en got=%b exp=001", ch_en); end
    checks++; if (bin_out !== 16'h0000) begin failures++; $display("FAIL reset_bin got=%h exp=0000", bin_out); end
    checks++; if (display_out !== 16'h0000) begin failures++; $display("FAIL reset_display got=%h exp=0000", display_out); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_debounce();
    int found;
    for (int i = 0; i < 21; i++) begin
      btn_mode = (i % 3 != 2);
      tick(1);
      checks++;
      if (src_state !== 2'd0) begin failures++; $display("FAIL glitch_src cyc=%0d got=%0d exp=0", i, src_state); end
    end
    btn_mode = 1'b1;
    found = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (src_state !== 2'd0) begin found = k; break; end
    end
    checks++;
    if (found != DEB + 3) begin failures++; $display("FAIL press_latency got=%0d exp=%0d", found, DEB + 3); end
    tick(20);
    apply_press(4'b0001);
    checks++;
    if (src_state !== 2'(m_src)) begin failures++; $display("FAIL hold_single_step got=%0d exp=%0d", src_state, m_src); end
    btn_mode = 1'b0;
    tick(DEB + 4);
  endtask

  task automatic test_switch();
    switches_in = 16'hA5C3;
    tick(1);
    checks++; if (bin_out !== 16'hA5C3) begin failures++; $display("FAIL switch_fixed got=%h exp=a5c3", bin_out); end
    for (int i = 0; i < 6; i++) begin
      switches_in = DATA_W'($urandom);
      tick(1);
      checks++; if (bin_out !== exp_bin()) begin failures++; $display("FAIL switch_rand got=%h exp=%h", bin_out, exp_bin()); end
    end
    press(4'b0100);
    bcd_in = 16'h1234;
    #1;
    checks++; if (display_out !== 16'h1234) begin failures++; $display("FAIL display_bcd got=%h exp=1234", display_out); end
    for (int i = 0; i < 4; i++) begin
      bcd_in = DATA_W'($urandom);
      #1;
      checks++;
      if (display_out !== (m_radix != 0 ? bcd_in : exp_bin())) begin
        failures++; $display("FAIL display_rand got=%h exp=%h", display_out, (m_radix != 0 ? bcd_in : exp_bin()));
      end
    end
    press(4'b0100);
    checks++; if (display_out !== switches_in) begin failures++; $display("FAIL display_hex got=%h exp=%h", display_out, switches_in); end
  endtask

  task automatic test_adc();
    logic [3:0] m;
    press(4'b0001);
    randomize_taps();
    taps[2*3+2] = 16'h0FFF;
    load_taps();
    press(4'b1000); press(4'b1000); press(4'b0010); press(4'b0010);
    checks++; if (ch_sel !== 2'd2) begin failures++; $display("FAIL adc_ch got=%0d exp=2", ch_sel); end
    checks++; if (ch_en !== 3'b100) begin failures++; $display("FAIL adc_ch_en got=%b exp=100", ch_en); end
    checks++; if (bin_out !== 16'h0FFF) begin failures++; $display("FAIL adc_bin got=%h exp=0fff", bin_out); end
    press(4'b1000);
    checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL ch_wrap got=%0d exp=0", ch_sel); end
    checks++; if (ch_en !== 3'b001) begin failures++; $display("FAIL ch_wrap_en got=%b exp=001", ch_en); end
    for (int i = 0; i < 10; i++) begin
      m = 4'($urandom_range(1, 7)) << 1;
      randomize_taps();
      bcd_in = DATA_W'($urandom);
      press(m);
      checks++; if (src_state !== 2'(m_src)) begin failures++; $display("FAIL rnd_src got=%0d exp=%0d", src_state, m_src); end
      checks++; if (proc_sel !== 2'(m_proc)) begin failures++; $display("FAIL rnd_proc got=%0d exp=%0d", proc_sel, m_proc); end
      checks++; if (ch_sel !== 2'(m_ch)) begin failures++; $display("FAIL rnd_ch got=%0d exp=%0d", ch_sel, m_ch); end
      checks++; if (ch_en !== NUM_CH'(1 << m_ch)) begin failures++; $display("FAIL rnd_ch_en got=%b exp=%b", ch_en, NUM_CH'(1 << m_ch)); end
      checks++; if (bin_out !== exp_bin()) begin failures++; $display("FAIL rnd_bin got=%h exp=%h", bin_out, exp_bin()); end
      checks++;
      if (display_out !== (m_radix != 0 ? bcd_in : exp_bin())) begin
        failures++; $display("FAIL rnd_display got=%h exp=%h", display_out, (m_radix != 0 ? bcd_in : exp_bin()));
      end
    end
  endtask

  task automatic test_simultaneous();
    int found;
    logic [1:0] old_proc;
    logic old_radix;
    old_proc = proc_sel;
    old_radix = radix_bcd;
    set_btns(4'b0110);
    found = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (proc_sel !== old_proc) begin found = k; break; end
    end
    checks++; if (found != DEB + 3) begin failures++; $display("FAIL simul_latency got=%0d exp=%0d", found, DEB + 3); end
    checks++; if (radix_bcd !== ~old_radix) begin failures++; $display("FAIL simul_radix got=%0d exp=%0d", radix_bcd, ~old_radix); end
    apply_press(4'b0110);
    set_btns(4'b0000);
    tick(DEB + 4);
    checks++; if (proc_sel !== 2'(m_proc)) begin failures++; $display("FAIL simul_proc got=%0d exp=%0d", proc_sel, m_proc); end
    checks++; if (radix_bcd !== 1'(m_radix)) begin failures++; $display("FAIL simul_radix_hold got=%0d exp=%0d", radix_bcd, m_radix); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_btns(4'b0000);
    tick(2);
    reset = 1'b0;
    model_reset();
  endtask

`ifdef AUTO_SCAN_EN
  task automatic test_scan();
    int exp_src, exp_ch, e1;
    do_reset();
    press(4'b0001);
    press(4'b0001);
    exp_src = 2;
    exp_ch = 0;
    for (int e = 0; e <= 60; e++) begin
      if (e == 0)  btn_mode = 1'b1;
      if (e == 10) btn_mode = 1'b0;
      if (e == 20) btn_ch = 1'b1;
      if (e == 30) btn_ch = 1'b0;
      if (e == 42) btn_mode = 1'b1;
      if (e == 52) btn_mode = 1'b0;
      tick(1);
      e1 = e + 1;
      if (e1 == DEB + 3) exp_src = 3;
      if (e1 == 42 + DEB + 3) exp_src = 0;
      if (e1 > DEB + 3 && e1 < 42 + DEB + 3 && (e1 - (DEB + 3)) % SCAN == 0) exp_ch = (exp_ch + 1) % NUM_CH;
      checks++; if (src_state !== 2'(exp_src)) begin failures++; $display("FAIL scan_src edge=%0d got=%0d exp=%0d", e1, src_state, exp_src); end
      checks++; if (ch_sel !== 2'(exp_ch)) begin failures++; $display("FAIL scan_ch edge=%0d got=%0d exp=%0d", e1, ch_sel, exp_ch); end
    end
    m_src = 0;
    m_ch = exp_ch;
    tick(DEB + 4);
  endtask
`else
  task automatic test_mode_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(4'b0001);
      checks++; if (src_state !== 2'(m_src)) begin failures++; $display("FAIL mode_cycle step=%0d got=%0d exp=%0d", i, src_state, m_src); end
      checks++; if (src_state === 2'd3) begin failures++; $display("FAIL mode_no_scan step=%0d got=3 exp=0..2", i); end
    end
  endtask
`endif

  task automatic test_reset_abort();
    switches_in = 16'h5A5A;
    press(4'b0100);
    press(4'b0010);
    press(4'b1000);
`ifdef AUTO_SCAN_EN
    while (m_src != 2) press(4'b0001);
    btn_mode = 1'b1;
    tick(DEB + 3);
    checks++; if (src_state !== 2'd3) begin failures++; $display("FAIL abort_enter_scan got=%0d exp=3", src_state); end
    btn_mode = 1'b0;
    tick(3);
`else
    if (m_src == 0) press(4'b0001);
`endif
    btn_proc = 1'b1;
    tick(3);
    reset = 1'b1;
    btn_proc = 1'b0;
    tick(1);
    model_reset();
    for (int r = 0; r < 2; r++) begin
      checks++; if (src_state !== 2'd0) begin failures++; $display("FAIL abort_src pass=%0d got=%0d exp=0", r, src_state); end
      checks++; if (proc_sel !== 2'd0) begin failures++; $display("FAIL abort_proc pass=%0d got=%0d exp=0", r, proc_sel); end
      checks++; if (radix_bcd !== 1'b0) begin failures++; $display("FAIL abort_radix pass=%0d got=%0d exp=0", r, radix_bcd); end
      checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL abort_ch pass=%0d got=%0d exp=0", r, ch_sel); end
      checks++; if (ch_en !== 3'b001) begin failures++; $display("FAIL abort_ch_en pass=%0d got=%b exp=001", r, ch_en); end
      checks++; if (bin_out !== 16'h0000) begin failures++; $display("FAIL abort_bin pass=%0d got=%h exp=0000", r, bin_out); end
      checks++; if (display_out !== 16'h0000) begin failures++; $display("FAIL abort_display pass=%0d got=%h exp=0000", r, display_out); end
      reset = 1'b0;
      tick(20);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_CH*3; i++) taps.push_back('0);
    reset = 1'b1;
    set_btns(4'b0000);
    switches_in = '0;
    bcd_in = '0;
    ch_data = '0;
    #1;
    test_reset();
    test_debounce();
    test_switch();
    test_adc();
    test_simultaneous();
`ifdef AUTO_SCAN_EN
    test_scan();
`else
    test_mode_cycle();
`endif
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_display_sequencer.md
# adc_display_sequencer

Parametrised front-panel controller that selects the 16-bit value shown on the seven-segment path. It chooses from all-zero, the slide switches, or one of NUM_CH converter channels, each offering raw, averaged and scaled taps. It debounces four push-buttons internally and steps a source/processing/radix/channel state from them. It drives one-hot channel enables and an optional auto-scan mode that cycles channels on a timer. It sits between the ADC/DAC processing blocks and the binary-to-BCD and seven-segment blocks.

## Interface
Parameters:
- NUM_CH, 3, number of converter channels (2..8).
- DATA_W, 16, sample and display width.
- DEBOUNCE_CYC, 1_000_000, cycles a synchronised button level must be stable before it is accepted (≥2).
- SCAN_CYC, 100_000_000, dwell cycles per channel in auto-scan (≥2; used only with AUTO_SCAN_EN).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- btn_mode  in  1  asynchronous button; steps the source state.
- btn_proc  in  1  asynchronous button; steps the processing tap.
- btn_radix  in  1  asynchronous button; toggles hex/BCD.
- btn_ch  in  1  asynchronous button; steps the channel.
- switches_in  in  DATA_W  switch value.
- ch_data  in  NUM_CH*3*DATA_W  packed taps; channel c, tap t (0 raw, 1 ave, 2 scaled) at bits [(3c+t)*DATA_W +: DATA_W].
- bcd_in  in  DATA_W  BCD conversion of bin_out from the external converter.
- bin_out  out  DATA_W  selected binary value (registered).
- display_out  out  DATA_W  bcd_in when radix_bcd, else bin_out (combinational).
- ch_sel  out  $clog2(NUM_CH)  current channel.
- ch_en  out  NUM_CH  one-hot enable, bit ch_sel set.
- proc_sel  out  2  0 raw, 1 ave, 2 scaled.
- src_state  out  2  0 ZERO, 1 SWITCH, 2 ADC, 3 SCAN.
- radix_bcd  out  1  1 = BCD display.

## Operation
- Each button passes through a 2-flop synchroniser. A counter then loads the synchronised level into the debounced level only after the level has differed from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- A rising edge of a debounced level gives a one-cycle press pulse. Release produces no pulse, and holding a button produces one pulse only.
- Source FSM on btn_mode press: ZERO→SWITCH→ADC→ZERO. With AUTO_SCAN_EN the sequence is ZERO→SWITCH→ADC→SCAN→ZERO.
- btn_proc press: proc_sel 0→1→2→0; the value 3 is never produced.
- btn_radix press: toggle radix_bcd.
- btn_ch press: ch_sel increments modulo NUM_CH (NUM_CH-1 wraps to 0). In SCAN, btn_ch presses are ignored.
- bin_out next value:
  - ZERO: 0.
  - SWITCH: switches_in.
  - ADC or SCAN: ch_data tap (ch_sel, proc_sel).
- ch_en = 1<<ch_sel in every state, including ZERO and SWITCH.
- Simultaneous press pulses on different buttons all take effect in the same cycle.
- bin_out is computed from the pre-update ch_sel, proc_sel and src_state. New settings appear in bin_out one cycle after they update.
- Reset values:
  - src_state 0, proc_sel 0, radix_bcd 0, ch_sel 0, ch_en 1.
  - bin_out 0 and display_out 0.
  - Synchronisers, debounce counters and debounced levels cleared to 0. A button held through reset is therefore seen as a fresh press after DEBOUNCE_CYC.
  - Scan timer cleared to 0.

## Timing
- Button latency: if a button is high from rising edge N onward, its press pulse is high in cycle N+2+DEBOUNCE_CYC. The affected state register updates at edge N+3+DEBOUNCE_CYC, and bin_out one edge later.
- Data latency: a ch_data or switches_in change is visible on bin_out after 1 edge. display_out follows bin_out and bcd_in with zero latency.
- Reset asserted mid-debounce or mid-scan aborts the operation with no pulse and no channel step.

## Configuration
- AUTO_SCAN_EN defined:
  - SCAN state exists.
  - Entering SCAN clears the scan timer.
  - ch_sel advances modulo NUM_CH each time the timer reaches SCAN_CYC-1; the timer then returns to 0.
  - Leaving SCAN keeps the current ch_sel.
- AUTO_SCAN_EN undefined:
  - No timer logic.
  - src_state never reaches 3.
  - btn_ch is always honoured.

## Test plan
All scenarios use NUM_CH=3, DEBOUNCE_CYC=4, SCAN_CYC=8.
- Reset, then btn_mode high with 1-cycle glitches every 3 cycles for 20 cycles → no state change. Then btn_mode held steady → src_state 0→1 exactly 7 edges after the steady high. Holding further → no second step.
- src_state=SWITCH with switches_in=16'hA5C3 → bin_out=16'hA5C3 one edge later. Set radix_bcd=1 with bcd_in=16'h1234 → display_out=16'h1234.
- src_state=ADC, ch 2 scaled tap=16'h0FFF: press btn_ch twice and btn_proc twice → ch_sel=2, ch_en=3'b100, bin_out=16'h0FFF. A third btn_ch press → ch_sel=0, ch_en=3'b001.
- btn_proc and btn_radix pressed on the same edge → proc_sel and radix_bcd both update in the same cycle.
- With AUTO_SCAN_EN, src_state=SCAN → ch_sel steps 0→1→2→0 every 8 cycles. A btn_ch press during SCAN → ignored. Without the macro, four btn_mode presses → src_state returns to 0 via 1 and 2 only.
- Reset asserted during scan and during an in-progress debounce → all outputs return to reset values on the next edge, with no spurious press afterwards.
